pwm_multi: RTL and testbench

Multi-channel PWM generator: N_CH channels share one period counter, each with its own duty and output polarity. Period, duty, polarity and alignment mode go through shadow registers and take effect only at a period boundary, so updates never produce glitches or truncated pulses. Supports edge-aligned and centre-aligned counting. Sits between the register interface and the pad drivers; this is the successor to the single-channel PWM core.

---
 rtl/pwm_multi_if.sv | 19 +
 rtl/pwm_multi.sv | 104 ++++++++++
 tb/tb_pwm_multi.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// rtl/pwm_multi_if.sv - configuration bus carrying shadow-register writes into pwm_multi
interface pwm_multi_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 16
);
  logic                    cfg_wr;
  logic                    center_mode;
  logic [WIDTH-1:0]        period;
  logic [N_CH*WIDTH-1:0]   duty;
  logic [N_CH-1:0]         polarity;

  modport master (
    output cfg_wr, center_mode, period, duty, polarity
  );

  modport slave (
    input cfg_wr, center_mode, period, duty, polarity
  );
endinterface

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shared counter and boundary-synchronised shadow registers
module pwm_multi #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable_i,
  pwm_multi_if.slave      cfg,
  output logic [N_CH-1:0] pwm_out_o,
  output logic            period_end_o,
  output logic            update_pending_o
);

  logic                  sh_mode_q, act_mode_q;
  logic [WIDTH-1:0]      sh_period_q, act_period_q;
  logic [N_CH*WIDTH-1:0] sh_duty_q, act_duty_q;
  logic [N_CH-1:0]       sh_pol_q, act_pol_q;

  logic                  pending_q, pending_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic                  dir_down_q, dir_down_d;
  logic [N_CH-1:0]       pwm_q, pwm_d;
  logic                  pe_q, pe_d;

  logic                  p_zero, tc, load;
  logic [WIDTH-1:0]      p_last;

  assign p_zero = (act_period_q == '0);
  assign p_last = act_period_q - WIDTH'(1);
  assign tc     = p_zero || (act_mode_q ? (dir_down_q && (cnt_q == '0))
                                        : (cnt_q == p_last));
  // While idle the active set follows the shadow so enable starts with current values.
  assign load   = pending_q && (tc || !enable_i);

  always_comb begin
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    if (!enable_i || tc) begin
      cnt_d      = '0;
      dir_down_d = 1'b0;
    end else if (!act_mode_q) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if (!dir_down_q) begin
      if (cnt_q == p_last) dir_down_d = 1'b1;
      else                 cnt_d      = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      pwm_d[k] = act_pol_q[k];
      if (enable_i && !p_zero && (cnt_q < act_duty_q[k*WIDTH +: WIDTH]))
        pwm_d[k] = ~act_pol_q[k];
    end
    pe_d      = tc && enable_i;
    pending_d = cfg.cfg_wr ? 1'b1 : (load ? 1'b0 : pending_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_mode_q    <= 1'b0;
      sh_period_q  <= '0;
      sh_duty_q    <= '0;
      sh_pol_q     <= '0;
      act_mode_q   <= 1'b0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      act_pol_q    <= '0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      dir_down_q   <= 1'b0;
      pwm_q        <= '0;
      pe_q         <= 1'b0;
    end else begin
      if (cfg.cfg_wr) begin
        sh_mode_q   <= cfg.center_mode;
        sh_period_q <= cfg.period;
        sh_duty_q   <= cfg.duty;
        sh_pol_q    <= cfg.polarity;
      end
      // Transfer reads the registered shadow, so a write in the same cycle waits one period.
      if (load) begin
        act_mode_q   <= sh_mode_q;
        act_period_q <= sh_period_q;
        act_duty_q   <= sh_duty_q;
        act_pol_q    <= sh_pol_q;
      end
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      pwm_q      <= pwm_d;
      pe_q       <= pe_d;
    end
  end

  assign pwm_out_o        = pwm_q;
  assign period_end_o     = pe_q;
  assign update_pending_o = pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - directed self-checking bench for pwm_multi
module tb_pwm_multi;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [3:0] pwm_out;
  logic       period_end;
  logic       update_pending;

  int errors = 0;
  int checks = 0;

  pwm_multi_if #(.N_CH(4), .WIDTH(16)) cfg_if ();

  pwm_multi #(.N_CH(4), .WIDTH(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable_i         (enable),
    .cfg              (cfg_if.slave),
    .pwm_out_o        (pwm_out),
    .period_end_o     (period_end),
    .update_pending_o (update_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic mode, input logic [15:0] p,
                         input logic [15:0] d3, input logic [15:0] d2,
                         input logic [15:0] d1, input logic [15:0] d0,
                         input logic [3:0] pol);
    cfg_if.center_mode = mode;
    cfg_if.period      = p;
    cfg_if.duty        = {d3, d2, d1, d0};
    cfg_if.polarity    = pol;
  endtask

  // Load a configuration while idle and confirm it becomes active without a period boundary.
  task automatic apply_idle(input logic mode, input logic [15:0] p,
                            input logic [15:0] d3, input logic [15:0] d2,
                            input logic [15:0] d1, input logic [15:0] d0,
                            input logic [3:0] pol);
    enable = 1'b0;
    set_cfg(mode, p, d3, d2, d1, d0, pol);
    cfg_if.cfg_wr = 1'b1;
    tick();
    cfg_if.cfg_wr = 1'b0;
    check("idle pending set", 32'(update_pending), 32'd1);
    tick();
    tick();
    check("idle pwm=pol", 32'(pwm_out), 32'(pol));
    check("idle pending clr", 32'(update_pending), 32'd0);
    check("idle period_end", 32'(period_end), 32'd0);
  endtask

  initial begin
    logic [3:0]  exp_pwm;
    logic [15:0] d0;
    int          c;
    int          cseq[8];
    logic [3:0]  pol_list[2];

    cseq     = '{0, 1, 2, 3, 3, 2, 1, 0};
    pol_list = '{4'b0000, 4'b1111};

    reset_n       = 1'b0;
    enable        = 1'b0;
    cfg_if.cfg_wr = 1'b0;
    set_cfg(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0000);
    tick();
    tick();
    check("reset pwm", 32'(pwm_out), 32'd0);
    check("reset period_end", 32'(period_end), 32'd0);
    check("reset pending", 32'(update_pending), 32'd0);
    reset_n = 1'b1;
    tick();

    // Edge mode P=10: ch0 duty 3 (later 7, 5, 2), ch1 0, ch2 10, ch3 5
    apply_idle(1'b0, 16'd10, 16'd5, 16'd10, 16'd0, 16'd3, 4'b0000);
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cfg_if.cfg_wr = 1'b0;
      if (i == 24) begin
        set_cfg(1'b0, 16'd10, 16'd5, 16'd10, 16'd0, 16'd7, 4'b0000);
        cfg_if.cfg_wr = 1'b1;
      end else if (i == 35) begin
        set_cfg(1'b0, 16'd10, 16'd5, 16'd10, 16'd0, 16'd5, 4'b0000);
        cfg_if.cfg_wr = 1'b1;
      end else if (i == 39) begin
        set_cfg(1'b0, 16'd10, 16'd5, 16'd10, 16'd0, 16'd2, 4'b0000);
        cfg_if.cfg_wr = 1'b1;
      end
      tick();
      c  = i % 10;
      d0 = (i < 30) ? 16'd3 : (i < 40) ? 16'd7 : (i < 50) ? 16'd5 : 16'd2;
      exp_pwm = {(c < 5), 1'b1, 1'b0, (c < int'(d0))};
      check($sformatf("edge pwm i=%0d", i), 32'(pwm_out), 32'(exp_pwm));
      check($sformatf("edge pe i=%0d", i), 32'(period_end), 32'(c == 9));
      check($sformatf("edge pending i=%0d", i), 32'(update_pending),
            32'(((i >= 24) && (i <= 28)) || ((i >= 35) && (i <= 48))));
    end
    cfg_if.cfg_wr = 1'b0;

    // Duty bounds P=8: 0, 8, 0xFFFF and 3, with both polarities
    for (int pi = 0; pi < 2; pi++) begin
      apply_idle(1'b0, 16'd8, 16'd3, 16'hFFFF, 16'd8, 16'd0, pol_list[pi]);
      enable = 1'b1;
      for (int j = 0; j < 16; j++) begin
        tick();
        c = j % 8;
        exp_pwm = {(c < 3), 1'b1, 1'b1, 1'b0} ^ pol_list[pi];
        check($sformatf("bound pwm pol=%0d j=%0d", pi, j), 32'(pwm_out), 32'(exp_pwm));
        check($sformatf("bound pe pol=%0d j=%0d", pi, j), 32'(period_end), 32'(c == 7));
      end
    end

    // Centre mode P=4: ch0 duty 2, ch1 0, ch2 4, ch3 1
    apply_idle(1'b1, 16'd4, 16'd1, 16'd4, 16'd0, 16'd2, 4'b0000);
    enable = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      c = cseq[j % 8];
      exp_pwm = {(c < 1), 1'b1, 1'b0, (c < 2)};
      check($sformatf("centre pwm j=%0d", j), 32'(pwm_out), 32'(exp_pwm));
      check($sformatf("centre pe j=%0d", j), 32'(period_end), 32'((j % 8) == 7));
    end

    // P=0: inactive outputs, tc every cycle, updates apply straight away
    apply_idle(1'b0, 16'd0, 16'd5, 16'd5, 16'd5, 16'd5, 4'b0101);
    enable = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("p0 pwm j=%0d", j), 32'(pwm_out), 32'h5);
      check($sformatf("p0 pe j=%0d", j), 32'(period_end), 32'd1);
    end
    set_cfg(1'b0, 16'd0, 16'd5, 16'd5, 16'd5, 16'd5, 4'b1010);
    cfg_if.cfg_wr = 1'b1;
    tick();
    cfg_if.cfg_wr = 1'b0;
    check("p0 pending set", 32'(update_pending), 32'd1);
    tick();
    check("p0 pending clr", 32'(update_pending), 32'd0);
    tick();
    check("p0 new pol", 32'(pwm_out), 32'hA);

    // Asynchronous reset mid-operation with an update pending
    cfg_if.cfg_wr = 1'b1;
    tick();
    cfg_if.cfg_wr = 1'b0;
    check("pre-reset pending", 32'(update_pending), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset pwm", 32'(pwm_out), 32'd0);
    check("async reset pending", 32'(update_pending), 32'd0);
    check("async reset pe", 32'(period_end), 32'd0);
    #3 reset_n = 1'b1;
    tick();
    check("post-reset pe", 32'(period_end), 32'd1);
    check("post-reset pwm", 32'(pwm_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
